// File: rtl/programmable_delay_timer.sv
// programmable_delay_timer: restartable prescaled countdown with one-shot/periodic expiry, Done pulse and sticky Expired.
module programmable_delay_timer #(
  parameter int WIDTH    = 11,
  parameter int PRESCALE = 1
) (
  input  logic             ClockIn,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Periodic,
  input  logic [WIDTH-1:0] Delay,
  output logic             Busy,
  output logic             Done,
  output logic             Expired,
  output logic [WIDTH-1:0] Remaining
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, dly_q, dly_d;
  logic [PW-1:0] pre_q, pre_d;
  logic per_q, per_d, done_q, done_d, exp_q, exp_d, tick;
  assign tick = pre_q == PMAX;
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dly_d   = dly_q;
    per_d   = per_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    exp_d   = exp_q;
    if (Abort) begin
      if (state_q == RUN) begin
        state_d = IDLE;
        rem_d   = '0;
        pre_d   = '0;
      end
    end else if (Start) begin
      pre_d = '0;
      if (Delay != '0) begin
        state_d = RUN;
        dly_d   = Delay;
        per_d   = Periodic;
        rem_d   = Delay;
        exp_d   = 1'b0;
      end else begin
        // zero delay expires immediately and never reloads
        state_d = IDLE;
        rem_d   = '0;
        done_d  = 1'b1;
        exp_d   = 1'b1;
      end
    end else if (state_q == RUN) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        if (rem_q == WIDTH'(1)) begin
          done_d  = 1'b1;
          exp_d   = 1'b1;
          rem_d   = per_q ? dly_q : '0;
          state_d = per_q ? RUN : IDLE;
        end else begin
          rem_d = rem_q - WIDTH'(1);
        end
      end
    end
  end
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dly_q   <= '0;
      per_q   <= 1'b0;
      pre_q   <= '0;
      done_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dly_q   <= dly_d;
      per_q   <= per_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
      exp_q   <= exp_d;
    end
  end
  assign Busy      = state_q == RUN;
  assign Done      = done_q;
  assign Expired   = exp_q;
  assign Remaining = rem_q;
endmodule

// File: tb/tb_programmable_delay_timer.sv
// tb_programmable_delay_timer: directed checks of one-shot, periodic, zero delay, abort, restart, max delay and async reset.
module tb_programmable_delay_timer;
  logic ClockIn = 1'b0, Reset = 1'b1, start1 = 1'b0, start4 = 1'b0, Abort = 1'b0, Periodic = 1'b0;
  logic [10:0] Delay = '0;
  logic busy1, done1, exp1, busy4, done4, exp4;
  logic [10:0] rem1, rem4;
  int n_chk = 0, n_err = 0;
  programmable_delay_timer #(.WIDTH(11), .PRESCALE(1)) dut1 (
    .ClockIn(ClockIn), .Reset(Reset), .Start(start1), .Abort(Abort), .Periodic(Periodic),
    .Delay(Delay), .Busy(busy1), .Done(done1), .Expired(exp1), .Remaining(rem1));
  programmable_delay_timer #(.WIDTH(11), .PRESCALE(4)) dut4 (
    .ClockIn(ClockIn), .Reset(Reset), .Start(start4), .Abort(Abort), .Periodic(Periodic),
    .Delay(Delay), .Busy(busy4), .Done(done4), .Expired(exp4), .Remaining(rem4));
  always #5 ClockIn = ~ClockIn;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic step();
    @(posedge ClockIn);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int cnt;
    logic seen;
    step();
    step();
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_exp", exp1, 0);
    chk("rst_rem", rem1, 0);
    Reset = 1'b0;
    // one-shot, P=1, Delay=5
    Delay = 11'd5; start1 = 1'b1; step(); start1 = 1'b0;
    chk("os_busy0", busy1, 1);
    chk("os_rem0", rem1, 5);
    chk("os_done0", done1, 0);
    for (int e = 1; e <= 6; e++) begin
      step();
      chk("os_rem", rem1, e <= 5 ? 5 - e : 0);
      chk("os_done", done1, e == 5);
      chk("os_busy", busy1, e < 5);
    end
    chk("os_exp", exp1, 1);
    // periodic, P=4, Delay=3
    Delay = 11'd3; Periodic = 1'b1; start4 = 1'b1; step(); start4 = 1'b0; Periodic = 1'b0;
    for (int e = 1; e <= 36; e++) begin
      step();
      chk("per_done", done4, e % 12 == 0);
      chk("per_busy", busy4, 1);
      chk("per_rem", rem4, 3 - ((e / 4) % 3));
    end
    chk("per_exp", exp4, 1);
    Abort = 1'b1; step(); Abort = 1'b0;
    chk("per_ab_busy", busy4, 0);
    chk("per_ab_rem", rem4, 0);
    chk("per_ab_done", done4, 0);
    chk("per_ab_exp", exp4, 1);
    // zero delay
    Delay = 11'd0; start1 = 1'b1; step(); start1 = 1'b0;
    chk("z_done", done1, 1);
    chk("z_busy", busy1, 0);
    chk("z_rem", rem1, 0);
    chk("z_exp", exp1, 1);
    step();
    chk("z_done_end", done1, 0);
    // abort mid-count
    Delay = 11'd10; start1 = 1'b1; step(); start1 = 1'b0;
    chk("ab_exp_clr", exp1, 0);
    step(); step(); step();
    Abort = 1'b1; step(); Abort = 1'b0;
    chk("ab_busy", busy1, 0);
    chk("ab_rem", rem1, 0);
    seen = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step();
      seen |= done1;
    end
    chk("ab_nodone", seen, 0);
    chk("ab_exp", exp1, 0);
    // restart at edge 3 with Delay=7
    Delay = 11'd10; start1 = 1'b1; step(); start1 = 1'b0;
    step(); step();
    Delay = 11'd7; start1 = 1'b1; step(); start1 = 1'b0;
    chk("rs_rem", rem1, 7);
    for (int e = 4; e <= 11; e++) begin
      step();
      chk("rs_done", done1, e == 10);
    end
    // abort and start together in RUN
    Delay = 11'd5; start1 = 1'b1; step();
    Abort = 1'b1; Delay = 11'd9; step(); Abort = 1'b0; start1 = 1'b0;
    chk("as_busy", busy1, 0);
    chk("as_rem", rem1, 0);
    chk("as_done", done1, 0);
    // start coinciding with expiry
    Delay = 11'd2; start1 = 1'b1; step(); start1 = 1'b0;
    step();
    Delay = 11'd4; start1 = 1'b1; step(); start1 = 1'b0;
    chk("se_rem", rem1, 4);
    chk("se_done", done1, 0);
    chk("se_busy", busy1, 1);
    chk("se_exp", exp1, 0);
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("se_done_later", done1, e == 4);
    end
    // maximum delay
    Delay = 11'd2047; start1 = 1'b1; step(); start1 = 1'b0;
    cnt = 0;
    for (int e = 1; e <= 2047; e++) begin
      step();
      if (done1) cnt++;
      if (e == 2046) chk("max_early", done1, 0);
    end
    chk("max_done", done1, 1);
    chk("max_cnt", cnt, 1);
    step();
    chk("max_done_end", done1, 0);
    chk("max_busy", busy1, 0);
    // asynchronous reset mid-count
    Delay = 11'd100; start1 = 1'b1; start4 = 1'b1; step(); start1 = 1'b0; start4 = 1'b0;
    step(); step(); step();
    chk("ar_busy_pre", busy1, 1);
    #3 Reset = 1'b1;
    #1;
    chk("ar_busy1", busy1, 0);
    chk("ar_rem1", rem1, 0);
    chk("ar_done1", done1, 0);
    chk("ar_exp1", exp1, 0);
    chk("ar_busy4", busy4, 0);
    chk("ar_rem4", rem4, 0);
    chk("ar_done4", done4, 0);
    chk("ar_exp4", exp4, 0);
    Reset = 1'b0;
    step();
    chk("ar_idle1", busy1, 0);
    chk("ar_idle4", busy4, 0);
    chk("ar_rem_after", rem1, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
